// File: rtl/reminder_timer_bank_pkg.sv
// Shared definitions for the reminder timer bank: mode encodings, channel
// state type and default sizing.
package reminder_timer_bank_pkg;

  localparam int unsigned DEF_TICK_DIV = 32'd50_000_000;
  localparam int unsigned DEF_CNT_W    = 32'd17;
  localparam int unsigned DEF_NUM_CH   = 32'd4;
  localparam int unsigned DEF_CH_W     = 32'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/reminder_prescaler.sv
// Shared prescaler: divides clk_i by TICK_DIV and emits a registered one-cycle
// tick on every wrap. ena_i low freezes the phase and suppresses the tick.
module reminder_prescaler
  import reminder_timer_bank_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  output logic tick_o
);

  localparam int unsigned   PW   = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 32'd1);
  localparam logic [PW-1:0] ONE  = PW'(32'd1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Next-state for the divider phase and the wrap tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (ena_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = {PW{1'b0}};
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // Divider phase and tick registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {PW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/reminder_timer_bank.sv
// Bank of NUM_CH programmable second-resolution reminder timers sharing one
// prescaler. Each channel has a sticky alert and a missed-alert overrun flag.
module reminder_timer_bank
  import reminder_timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned CH_W     = DEF_CH_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic              cfg_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic              cfg_mode_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] tm_out_o,
  output logic [NUM_CH-1:0] missed_o,
  output logic              any_alert_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic              tick_s;
  logic [NUM_CH-1:0] tm_vec_s;
  logic [NUM_CH-1:0] miss_vec_s;
  logic              any_q;

  reminder_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ena_i  (ena_i),
    .tick_o (tick_s)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q;
    ch_state_e        state_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             mode_q;
    logic             mode_d;
    logic             tm_q;
    logic             tm_d;
    logic             miss_q;
    logic             miss_d;
    logic             cfg_hit_s;

    assign cfg_hit_s = cfg_i && (cfg_ch_i == CH_W'(g));

    // Channel next-state: config beats tick and ack; expiry beats ack on Tm_out.
    always_comb begin
      state_d  = state_q;
      period_d = period_q;
      count_d  = count_q;
      mode_d   = mode_q;
      tm_d     = tm_q;
      miss_d   = miss_q;
      if (cfg_hit_s) begin
        period_d = cfg_period_i;
        count_d  = cfg_period_i;
        mode_d   = cfg_mode_i;
        tm_d     = 1'b0;
        miss_d   = 1'b0;
        state_d  = (cfg_period_i != CNT_ZERO) ? ST_RUN : ST_IDLE;
      end else begin
        if (ack_i[g]) begin
          tm_d   = 1'b0;
          miss_d = 1'b0;
        end else begin
          tm_d   = tm_q;
          miss_d = miss_q;
        end
        if (tick_s && (state_q == ST_RUN)) begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else begin
            // Expiry: an alert still pending without ack is an overrun.
            tm_d = 1'b1;
            if (tm_q && !ack_i[g]) begin
              miss_d = 1'b1;
            end else begin
              miss_d = miss_d;
            end
            case (mode_q)
              MODE_PERIODIC: begin
                count_d = period_q;
                state_d = ST_RUN;
              end
              MODE_ONESHOT: begin
                count_d = CNT_ZERO;
                state_d = ST_IDLE;
              end
              default: begin
                count_d = CNT_ZERO;
                state_d = ST_IDLE;
              end
            endcase
          end
        end else begin
          count_d = count_q;
          state_d = state_q;
        end
      end
    end

    // Channel state, configuration and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= ST_IDLE;
        period_q <= CNT_ZERO;
        count_q  <= CNT_ZERO;
        mode_q   <= MODE_ONESHOT;
        tm_q     <= 1'b0;
        miss_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        period_q <= period_d;
        count_q  <= count_d;
        mode_q   <= mode_d;
        tm_q     <= tm_d;
        miss_q   <= miss_d;
      end
    end

    assign tm_vec_s[g]   = tm_q;
    assign miss_vec_s[g] = miss_q;
  end

  // Summary alert, one cycle behind the per-channel flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |tm_vec_s;
    end
  end

  assign tm_out_o    = tm_vec_s;
  assign missed_o    = miss_vec_s;
  assign any_alert_o = any_q;

endmodule

// File: tb/tb_reminder_timer_bank.sv
// Directed bench for reminder_timer_bank with TICK_DIV=4, NUM_CH=4, CNT_W=8.
module tb_reminder_timer_bank;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cfg;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_mode;
  logic [3:0] ack;
  logic [3:0] tm_out;
  logic [3:0] missed;
  logic       any_alert;

  int tests_run = 0;
  int tests_failed = 0;

  reminder_timer_bank #(
    .NUM_CH   (4),
    .CNT_W    (8),
    .TICK_DIV (4),
    .CH_W     (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ena_i        (ena),
    .cfg_i        (cfg),
    .cfg_ch_i     (cfg_ch),
    .cfg_period_i (cfg_period),
    .cfg_mode_i   (cfg_mode),
    .ack_i        (ack),
    .tm_out_o     (tm_out),
    .missed_o     (missed),
    .any_alert_o  (any_alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] per, input logic mode);
    cfg        = 1'b1;
    cfg_ch     = ch;
    cfg_period = per;
    cfg_mode   = mode;
  endtask

  // Comments E<n> mark the number of rising edges since Ena was first raised.
  initial begin
    rst_n = 1'b0; ena = 1'b0; cfg = 1'b0; cfg_ch = 2'd0;
    cfg_period = 8'd0; cfg_mode = 1'b0; ack = 4'b0000;
    wait_n(3);
    rst_n = 1'b1;

    // Step 1: idle with Ena low
    wait_n(50);
    chk("idle_tm", {28'd0, tm_out}, 32'h0);
    chk("idle_missed", {28'd0, missed}, 32'h0);
    chk("idle_any", {31'd0, any_alert}, 32'h0);

    // Step 2: ch0 one-shot period 3
    write_cfg(2'd0, 8'd3, 1'b0);
    wait_n(1);
    cfg = 1'b0; ena = 1'b1;                       // E0
    wait_n(12);                                   // E12
    chk("ch0_before_expiry", {28'd0, tm_out}, 32'h0);
    wait_n(1);                                    // E13
    chk("ch0_expiry_tm", {28'd0, tm_out}, 32'h1);
    chk("ch0_any_lag", {31'd0, any_alert}, 32'h0);
    wait_n(1);                                    // E14
    chk("ch0_any_set", {31'd0, any_alert}, 32'h1);
    wait_n(8);                                    // E22
    chk("ch0_oneshot_hold_tm", {28'd0, tm_out}, 32'h1);
    chk("ch0_oneshot_no_missed", {28'd0, missed}, 32'h0);
    ack = 4'b0001;
    wait_n(1);                                    // E23
    ack = 4'b0000;
    chk("ch0_ack_clears", {28'd0, tm_out}, 32'h0);
    chk("ch0_any_still_lag", {31'd0, any_alert}, 32'h1);
    wait_n(1);                                    // E24
    chk("ch0_any_cleared", {31'd0, any_alert}, 32'h0);
    wait_n(8);                                    // E32
    chk("ch0_stays_idle", {28'd0, tm_out}, 32'h0);

    // Step 3: ch1 periodic period 2, no ack
    wait_n(1);                                    // E33
    write_cfg(2'd1, 8'd2, 1'b1);
    wait_n(1);                                    // E34, loaded
    cfg = 1'b0;
    wait_n(6);                                    // E40
    chk("ch1_before_tick2", {28'd0, tm_out}, 32'h0);
    wait_n(1);                                    // E41
    chk("ch1_tick2_tm", {28'd0, tm_out}, 32'h2);
    chk("ch1_tick2_missed", {28'd0, missed}, 32'h0);
    wait_n(7);                                    // E48
    chk("ch1_before_tick4", {28'd0, missed}, 32'h0);
    wait_n(1);                                    // E49
    chk("ch1_tick4_missed", {28'd0, missed}, 32'h2);
    chk("ch1_tick4_tm", {28'd0, tm_out}, 32'h2);
    ack = 4'b0010;
    wait_n(1);                                    // E50
    ack = 4'b0000;
    chk("ch1_ack_tm", {28'd0, tm_out}, 32'h0);
    chk("ch1_ack_missed", {28'd0, missed}, 32'h0);
    wait_n(6);                                    // E56
    chk("ch1_before_tick6", {28'd0, tm_out}, 32'h0);
    wait_n(1);                                    // E57
    chk("ch1_tick6_tm", {28'd0, tm_out}, 32'h2);
    write_cfg(2'd1, 8'd0, 1'b0);
    wait_n(1);                                    // E58, ch1 disarmed
    chk("ch1_disarm_clears", {28'd0, tm_out}, 32'h0);

    // Step 4: ch2 one-shot period 5 with a 20-cycle Ena freeze
    write_cfg(2'd2, 8'd5, 1'b0);
    wait_n(1);                                    // E59, loaded
    cfg = 1'b0;
    wait_n(11);                                   // E70, count 2
    ena = 1'b0;
    wait_n(20);                                   // E90
    chk("ch2_frozen", {28'd0, tm_out}, 32'h0);
    ena = 1'b1;
    wait_n(6);                                    // E96
    chk("ch2_before_delayed_expiry", {28'd0, tm_out}, 32'h0);
    wait_n(1);                                    // E97
    chk("ch2_delayed_expiry", {28'd0, tm_out}, 32'h4);
    ack = 4'b0100;
    wait_n(1);                                    // E98
    ack = 4'b0000;
    chk("ch2_ack", {28'd0, tm_out}, 32'h0);

    // Step 5a: ack coinciding with expiry (ch0 periodic period 1)
    write_cfg(2'd0, 8'd1, 1'b1);
    wait_n(1);                                    // E99
    cfg = 1'b0;
    wait_n(2);                                    // E101
    chk("ch0_p1_first_expiry", {28'd0, tm_out}, 32'h1);
    wait_n(3);                                    // E104
    ack = 4'b0001;
    wait_n(1);                                    // E105, expiry with ack
    ack = 4'b0000;
    chk("ack_expiry_tm_kept", {28'd0, tm_out}, 32'h1);
    chk("ack_expiry_no_missed", {28'd0, missed}, 32'h0);
    write_cfg(2'd0, 8'd0, 1'b0);
    wait_n(1);                                    // E106
    cfg = 1'b0;
    chk("ch0_disarm", {28'd0, tm_out}, 32'h0);

    // Step 5b: config of ch3 in the tick cycle loses the tick
    wait_n(2);                                    // E108
    write_cfg(2'd3, 8'd3, 1'b0);
    wait_n(1);                                    // E109, load with tick
    cfg = 1'b0;
    wait_n(11);                                   // E120
    chk("ch3_cfg_tick_no_early", {28'd0, tm_out}, 32'h0);
    wait_n(1);                                    // E121
    chk("ch3_cfg_tick_expiry", {28'd0, tm_out}, 32'h8);

    // Step 5c: period 0 on ch3 together with ack
    write_cfg(2'd3, 8'd0, 1'b0);
    ack = 4'b1000;
    wait_n(1);                                    // E122
    cfg = 1'b0; ack = 4'b0000;
    chk("ch3_cfg_ack_tm", {28'd0, tm_out}, 32'h0);
    chk("ch3_cfg_ack_missed", {28'd0, missed}, 32'h0);
    wait_n(8);                                    // E130
    chk("ch3_idle_tm", {28'd0, tm_out}, 32'h0);
    chk("ch3_idle_any", {31'd0, any_alert}, 32'h0);

    // Step 6: async reset with two alerts pending
    write_cfg(2'd0, 8'd1, 1'b0);
    wait_n(1);                                    // E131
    write_cfg(2'd1, 8'd2, 1'b1);
    wait_n(1);                                    // E132
    cfg = 1'b0;
    wait_n(5);                                    // E137
    chk("pre_reset_tm", {28'd0, tm_out}, 32'h3);
    chk("pre_reset_any", {31'd0, any_alert}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tm", {28'd0, tm_out}, 32'h0);
    chk("async_reset_missed", {28'd0, missed}, 32'h0);
    chk("async_reset_any", {31'd0, any_alert}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(40);
    chk("post_reset_tm", {28'd0, tm_out}, 32'h0);
    chk("post_reset_missed", {28'd0, missed}, 32'h0);
    chk("post_reset_any", {31'd0, any_alert}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
